ca_prn_sweep_ctrl: RTL

- Sequencer that shares the single C/A code generator (CA_code) across an acquisition PRN sweep.
- For each PRN in a programmed range it:
  - resets the generator and loads its prn_select;
  - runs the generator for a programmable number of full code periods (dwell);
  - then advances to the next PRN.
- Sits between the acquisition correlator (which raises detect) and CA_code. It provides chip-valid and epoch timing to the correlator and reports the found PRN.

---
 rtl/ca_prn_sweep_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ca_prn_sweep_ctrl.sv
// Acquisition PRN sweep sequencer: shares one C/A code generator across a PRN range,
// dwelling a programmable number of code periods per PRN and reporting a correlator hit.
module ca_prn_sweep_ctrl #(
  parameter int CHIPS_PER_CODE = 1023,
  parameter int DWELL_W        = 8,
  parameter int PRN_MAX        = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [5:0]         prn_first,
  input  logic [5:0]         prn_last,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               detect,
  input  logic               ca_code_in,
  output logic               gen_rst,
  output logic [5:0]         gen_prn_select,
  output logic               chip,
  output logic               chip_valid,
  output logic               epoch,
  output logic [5:0]         prn_current,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [5:0]         found_prn
);

  localparam int CW = (CHIPS_PER_CODE > 1) ? $clog2(CHIPS_PER_CODE) : 1;
  localparam logic [CW-1:0] CHIP_LAST = CW'(CHIPS_PER_CODE - 1);
  localparam logic [5:0]    PRN_MAX_L = 6'(PRN_MAX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      chip_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_last;
  logic               range_ok;
  logic               dwell_done;
  logic               last_prn;

  assign range_ok   = (prn_first != 6'd0) && (prn_first <= prn_last) && (prn_last <= PRN_MAX_L);
  // A dwell of zero behaves as one code period.
  assign dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  // >= rather than == keeps the sweep moving if dwell/prn_last are lowered mid-run.
  assign dwell_done = (dwell_cnt >= dwell_last);
  assign last_prn   = (prn_current >= prn_last);

  assign chip           = ca_code_in;
  assign gen_rst        = (state != S_RUN);
  assign gen_prn_select = prn_current;
  assign chip_valid     = (state == S_RUN);
  assign epoch          = (state == S_RUN) && (chip_cnt == CHIP_LAST);
  assign busy           = (state == S_LOAD) || (state == S_RUN);
  assign done           = (state == S_FINISH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      prn_current <= 6'd1;
      chip_cnt    <= '0;
      dwell_cnt   <= '0;
      found       <= 1'b0;
      found_prn   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            found     <= 1'b0;
            found_prn <= '0;
            if (range_ok) begin
              prn_current <= prn_first;
              state       <= S_LOAD;
            end else begin
              state <= S_FINISH;
            end
          end
        end
        S_LOAD: begin
          chip_cnt  <= '0;
          dwell_cnt <= '0;
          if (abort) begin
            found <= 1'b0;
            state <= S_IDLE;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // Priority: abort, then detect, then epoch bookkeeping.
          if (abort) begin
            found <= 1'b0;
            state <= S_IDLE;
          end else if (detect) begin
            found     <= 1'b1;
            found_prn <= prn_current;
            state     <= S_FINISH;
          end else if (chip_cnt == CHIP_LAST) begin
            chip_cnt <= '0;
            if (dwell_done) begin
              if (last_prn) begin
                state <= S_FINISH;
              end else begin
                prn_current <= prn_current + 6'd1;
                state       <= S_LOAD;
              end
            end else begin
              dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end
          end else begin
            chip_cnt <= chip_cnt + CW'(1);
          end
        end
        S_FINISH: begin
          if (abort) found <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
